div_issue: RTL

Execute-stage initiator for the iterative divider. Decodes DIV/DIVU in EX, then latches and holds the operands. Drives the divider's start/annul/signed handshake and raises the pipeline stall request until the result returns. Presents the quotient and remainder as a HI/LO write, and holds it until the EX stage advances. Handles flush and watchdog recovery so the divider is always back in its free state before the next issue.

---
 rtl/div_issue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/div_issue.sv
// div_issue: EX-stage initiator for the iterative divider.
// Owns the start/annul handshake, the pipeline stall request and the HI/LO write of the result.
`default_nettype none

module div_issue #(
  parameter int TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic        stall_ex_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_o
);

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
  localparam int         CNT_W       = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               start_n, annul_n, whilo_n;
  logic               latch_ops, capture;
  logic               is_div;

  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    start_n    = div_start_o;
    annul_n    = 1'b0;
    whilo_n    = whilo_o;
    latch_ops  = 1'b0;
    capture    = 1'b0;
    err_o      = 1'b0;
    stallreq_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_div && !flush_i) begin
          state_n    = S_BUSY;
          start_n    = 1'b1;
          latch_ops  = 1'b1;
          cnt_n      = '0;
          stallreq_o = 1'b1;
        end
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        cnt_n      = cnt + CNT_W'(1);
        if (flush_i) begin
          state_n = S_ABORT;
          start_n = 1'b0;
          annul_n = 1'b1;
          cnt_n   = '0;
        end else if (div_ready_i) begin
          state_n = S_DONE;
          capture = 1'b1;
          whilo_n = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n = S_ABORT;
          start_n = 1'b0;
          err_o   = 1'b1;
          cnt_n   = '0;
        end
      end
      S_DONE: begin
        // start stays high so the divider parks in its end state until EX moves on
        if (flush_i || !stall_ex_i) begin
          state_n = S_IDLE;
          start_n = 1'b0;
          whilo_n = 1'b0;
        end
      end
      S_ABORT: begin
        // two cycles of start low lets the divider fall back to free from any state
        stallreq_o = 1'b1;
        start_n    = 1'b0;
        whilo_n    = 1'b0;
        cnt_n      = cnt + CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      div_start_o   <= 1'b0;
      div_annul_o   <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      whilo_o       <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      div_start_o <= start_n;
      div_annul_o <= annul_n;
      whilo_o     <= whilo_n;
      if (latch_ops) begin
        div_opdata1_o <= reg1_i;
        div_opdata2_o <= reg2_i;
        div_signed_o  <= (aluop_i == EXE_DIV_OP);
      end
      if (capture) begin
        hi_o <= div_result_i[63:32];
        lo_o <= div_result_i[31:0];
      end
    end
  end

endmodule

`default_nettype wire
